y86_fetch_ctrl: RTL
===================

Name: y86_fetch_ctrl

Overview:
PC sequencer and F/D pipeline-register controller for the Y86 fetch stage. Drives the PC into the combinational fetch unit and predicts the next PC (valC for JXX/CALL, valP otherwise). Captures decoded fields into the D register under a valid/ready handshake with decode. Handles mispredict redirects from execute, stalls on RET until writeback supplies the return address, and freezes on HALT, invalid instructions or imem errors.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
STAT_W, 3, width of the status code

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
pc_o  out  64  PC presented to fetch
f_icode_i  in  4  fetch icode
f_ifun_i  in  4  fetch ifun
f_rA_i  in  4  fetch rA
f_rB_i  in  4  fetch rB
f_valC_i  in  64  fetch constant
f_valP_i  in  64  fetch sequential PC
f_instr_valid_i  in  1  fetch legal-instruction flag
f_imem_error_i  in  1  fetch address error
d_ready_i  in  1  decode accepts the D register this cycle
d_valid_o  out  1  D register holds an instruction
d_icode_o  out  4  D icode
d_ifun_o  out  4  D ifun
d_rA_o  out  4  D rA
d_rB_o  out  4  D rB
d_valC_o  out  64  D valC
d_valP_o  out  64  D valP
d_stat_o  out  3  D status: AOK=1, HLT=2, ADR=3, INS=4
redirect_valid_i  in  1  execute reports a mispredict
redirect_pc_i  in  64  corrected PC (execute valA)
ret_done_i  in  1  writeback delivers the RET target
ret_pc_i  in  64  return address (W_valM)
state_o  out  2  RUN=0, RET_WAIT=1, HALTED=2
fetch_cnt_o  out  32  count of captured instructions

Behaviour:
- Reset values (async, rst_i=1): pc_o=RESET_PC, state=RUN, d_valid_o=0, d_icode_o=0 (NOP), d_ifun/rA/rB = 0/F/F, d_valC/valP=0, d_stat_o=AOK, fetch_cnt_o=0. Deassertion is used synchronously.
- Fetch is combinational. Fields for pc_o are available in the same cycle. A capture updates the D register and pc_o on the next edge: one-cycle latency.
- Capture condition: state==RUN && (!d_valid_o || d_ready_i) && !redirect_valid_i.
- On capture:
  - d_valid_o<=1 and all fields copied.
  - stat = ADR if imem_error, else INS if !instr_valid, else HLT if icode==1, else AOK. ADR takes precedence over INS, and INS over HLT.
  - fetch_cnt_o increments and wraps at 2^32.
- Next PC on capture:
  - icode 7 (JXX, any ifun) or 8 (CALL): valC.
  - icode 9 (RET): pc_o held; state->RET_WAIT.
  - stat != AOK: pc_o held; state->HALTED.
  - otherwise: valP.
- Stall: d_valid_o && !d_ready_i means the D register and pc_o hold. No capture and no count.
- RET_WAIT / HALTED:
  - No captures.
  - If d_valid_o && d_ready_i, then d_valid_o<=0 (bubbles follow).
  - fetch inputs are ignored.
- ret_done_i: honoured only in RET_WAIT. pc_o<=ret_pc_i, state->RUN, no capture that cycle. Ignored in RUN and HALTED.
- redirect_valid_i (highest priority, any state, overrides stall and ret_done_i):
  - pc_o<=redirect_pc_i, d_valid_o<=0 (flush the wrong-path D instruction), state->RUN.
  - No capture that cycle.
  - This undoes a HALT or RET fetched on a wrong path.
- HALTED is left only by redirect or reset.
- A reset mid-stall or mid-RET_WAIT restores the reset values immediately; any pending ret or redirect is lost.
- PC arithmetic is 64-bit with no wrap checks. Out-of-range addresses are reported by fetch through imem_error.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants NOP..POPL
  - STAT_AOK/HLT/ADR/INS
  - fetch-ctrl state encodings RUN/RET_WAIT/HALTED
  - the PC width
- One natural sub-module, y86_pc_predict: combinational next-PC select (icode, valC, valP -> predPC).
- The FSM, D register and counter stay in the top module.

Test Plan:
- Reset then stream at 0: irmovq (icode 3, valP=10) then addq (valP=12), d_ready_i=1 -> pc_o sequence 0,10,12; d_stat_o=AOK; fetch_cnt_o=2.
- jmp with valC=0x40 at PC 0x20 -> next pc_o=0x40; redirect_valid_i with redirect_pc_i=0x29 two cycles later -> pc_o=0x29, d_valid_o=0, state RUN.
- RET at 0x50 -> state=RET_WAIT and pc_o held at 0x50 for 5 cycles with d_valid_o dropping after accept; ret_done_i with ret_pc_i=0x18 -> pc_o=0x18, state RUN.
- HALT fetched -> d_stat_o=2, state HALTED; later redirect_pc_i=0x30 -> resumes RUN at 0x30. Separately, imem_error with icode 0xF -> stat=3 (ADR over INS).
- d_ready_i=0 for 3 cycles with d_valid_o=1 -> D fields, pc_o and fetch_cnt_o unchanged; redirect in the middle of the stall still flushes.
- Assert rst_i asynchronously mid-RET_WAIT between edges -> outputs return to reset values before the next edge; fetch_cnt_o at 0xFFFFFFFF wraps to 0 on the next capture.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes, fetch-control states, D-register payload.
package y86_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned STAT_BW = 3;
  localparam int unsigned CNT_W   = 32;

  // Instruction codes
  localparam logic [ICODE_W-1:0] I_NOP    = 4'h0;
  localparam logic [ICODE_W-1:0] I_HALT   = 4'h1;
  localparam logic [ICODE_W-1:0] I_RRMOVL = 4'h2;
  localparam logic [ICODE_W-1:0] I_IRMOVL = 4'h3;
  localparam logic [ICODE_W-1:0] I_RMMOVL = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVL = 4'h5;
  localparam logic [ICODE_W-1:0] I_OPL    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHL  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPL   = 4'hB;

  // Register id meaning "no register"
  localparam logic [REG_W-1:0] R_NONE = 4'hF;

  // Status codes
  localparam logic [STAT_BW-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_BW-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_BW-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_BW-1:0] STAT_INS = 3'd4;

  // Fetch-control state encodings
  typedef enum logic [1:0] {
    FC_RUN      = 2'd0,
    FC_RET_WAIT = 2'd1,
    FC_HALTED   = 2'd2
  } fc_state_e;

  // F/D pipeline register payload
  typedef struct packed {
    logic [ICODE_W-1:0] icode;
    logic [3:0]         ifun;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [PC_W-1:0]    valc;
    logic [PC_W-1:0]    valp;
    logic [STAT_BW-1:0] stat;
  } d_reg_t;

  localparam d_reg_t D_RESET = '{
    icode: I_NOP,
    ifun:  4'h0,
    ra:    R_NONE,
    rb:    R_NONE,
    valc:  '0,
    valp:  '0,
    stat:  STAT_AOK
  };

  // Fetch status: address error beats illegal instruction, which beats halt
  function automatic logic [STAT_BW-1:0] fetch_stat(input logic               imem_error,
                                                    input logic               instr_valid,
                                                    input logic [ICODE_W-1:0] icode);
    logic [STAT_BW-1:0] s;
    s = STAT_AOK;
    if (imem_error)          s = STAT_ADR;
    else if (!instr_valid)   s = STAT_INS;
    else if (icode == I_HALT) s = STAT_HLT;
    return s;
  endfunction

endpackage

// File: rtl/y86_pc_predict.sv
// Next-PC prediction: branches and calls are predicted taken to valC, everything else falls through to valP.
module y86_pc_predict
  import y86_pkg::*;
(
  input  logic [ICODE_W-1:0] icode,
  input  logic [PC_W-1:0]    valc,
  input  logic [PC_W-1:0]    valp,
  output logic [PC_W-1:0]    pred_pc_c
);

  // Select the predicted PC
  always_comb begin
    pred_pc_c = valp;
    if (icode == I_JXX || icode == I_CALL) pred_pc_c = valc;
  end

endmodule

// File: rtl/y86_fetch_ctrl.sv
// Y86 fetch-stage PC sequencer and F/D pipeline register with decode handshake,
// mispredict redirect, RET stall and HALT/fault freeze.
module y86_fetch_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned STAT_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [PC_W-1:0]    pc_o,
  input  logic [3:0]         f_icode_i,
  input  logic [3:0]         f_ifun_i,
  input  logic [3:0]         f_rA_i,
  input  logic [3:0]         f_rB_i,
  input  logic [PC_W-1:0]    f_valC_i,
  input  logic [PC_W-1:0]    f_valP_i,
  input  logic               f_instr_valid_i,
  input  logic               f_imem_error_i,
  input  logic               d_ready_i,
  output logic               d_valid_o,
  output logic [3:0]         d_icode_o,
  output logic [3:0]         d_ifun_o,
  output logic [3:0]         d_rA_o,
  output logic [3:0]         d_rB_o,
  output logic [PC_W-1:0]    d_valC_o,
  output logic [PC_W-1:0]    d_valP_o,
  output logic [STAT_W-1:0]  d_stat_o,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               ret_done_i,
  input  logic [PC_W-1:0]    ret_pc_i,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  fc_state_e          state_q;
  d_reg_t             d_q;
  logic [PC_W-1:0]    pc_q;
  logic               d_valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               capture_c;
  logic               accept_c;
  logic [STAT_BW-1:0] f_stat_c;
  logic [PC_W-1:0]    pred_pc_c;

  y86_pc_predict u_pc_predict (
    .icode     (f_icode_i),
    .valc      (f_valC_i),
    .valp      (f_valP_i),
    .pred_pc_c (pred_pc_c)
  );

  // Capture qualification and fetch status of the instruction at pc_q
  always_comb begin
    accept_c  = 1'b0;
    capture_c = 1'b0;
    f_stat_c  = STAT_AOK;
    accept_c  = d_valid_q && d_ready_i;
    capture_c = (state_q == FC_RUN) && (!d_valid_q || d_ready_i) && !redirect_valid_i;
    f_stat_c  = fetch_stat(f_imem_error_i, f_instr_valid_i, f_icode_i);
  end

  // Sequencer FSM, PC, D register and capture counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FC_RUN;
      pc_q      <= RESET_PC;
      d_q       <= D_RESET;
      d_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else if (redirect_valid_i) begin
      // Mispredict: flush wrong-path D entry and resume at the corrected PC
      pc_q      <= redirect_pc_i;
      d_valid_q <= 1'b0;
      state_q   <= FC_RUN;
    end else begin
      unique case (state_q)
        FC_RUN: begin
          if (capture_c) begin
            d_valid_q <= 1'b1;
            d_q.icode <= f_icode_i;
            d_q.ifun  <= f_ifun_i;
            d_q.ra    <= f_rA_i;
            d_q.rb    <= f_rB_i;
            d_q.valc  <= f_valC_i;
            d_q.valp  <= f_valP_i;
            d_q.stat  <= f_stat_c;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (f_stat_c != STAT_AOK) begin
              state_q <= FC_HALTED;
            end else if (f_icode_i == I_RET) begin
              state_q <= FC_RET_WAIT;
            end else begin
              pc_q    <= pred_pc_c;
            end
          end
        end
        FC_RET_WAIT: begin
          if (accept_c) d_valid_q <= 1'b0;
          if (ret_done_i) begin
            pc_q    <= ret_pc_i;
            state_q <= FC_RUN;
          end
        end
        FC_HALTED: begin
          if (accept_c) d_valid_q <= 1'b0;
        end
        default: begin
          state_q <= FC_RUN;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign d_valid_o   = d_valid_q;
  assign d_icode_o   = d_q.icode;
  assign d_ifun_o    = d_q.ifun;
  assign d_rA_o      = d_q.ra;
  assign d_rB_o      = d_q.rb;
  assign d_valC_o    = d_q.valc;
  assign d_valP_o    = d_q.valp;
  assign d_stat_o    = STAT_W'(d_q.stat);
  assign state_o     = state_q;
  assign fetch_cnt_o = cnt_q;

endmodule
